line_clearer: RTL
=================

// Module: line_clearer
// PURPOSE
//  Lock-and-clear stage after the game-logic FSM ("update static" step).
//  Merges the landed 4x4 float piece into the 20x10 static board.
//  Scans rows, removes full rows, compacts the remaining rows downward and returns the new board.
//  Reports cleared lines to scoreCount via hit/lineCount.
// PARAMETERS
//  ROWS   20  board height; row 0 = bottom
//  COLS   10  board width; col 0 = left
// PORTS
//  clk        in   1          system clock
//  rst        in   1          synchronous, active-high reset
//  start      in   1          1-cycle request; accepted only in IDLE
//  board_in   in   ROWS*COLS  static board; bit r*COLS+c = row r, col c
//  float_in   in   16         piece; bit i*4+j -> board row y+i, col x+j
//  x          in   4          piece column origin
//  y          in   5          piece row origin
//  busy       out  1          high from the cycle after start until done
//  done       out  1          1-cycle pulse; board_out/hit/lineCount valid
//  board_out  out  ROWS*COLS  compacted board; held until next done
//  hit        out  1          pulse with done when >=1 row cleared
//  lineCount  out  2          rows cleared minus 1 (00=1 .. 11=4); held
//  game_over  out  1          lock-out flag (see CONFIGURATION)
// BEHAVIOUR
//  - Clock and reset: single clock clk; rst is synchronous and active-high.
//  - Reset: state IDLE; busy=done=hit=game_over=0; lineCount=0; board_out=0.
//  - rst mid-operation aborts the operation. No done is issued. A start in the same cycle is ignored.
//  - Inputs are sampled at start into internal regs. Later input changes have no effect.
//  - State machine:
//    - IDLE  -> MERGE on start.
//    - MERGE: 1 cycle. work = board_in | placed piece.
//      Piece cells with y+i >= ROWS or x+j >= COLS are dropped.
//    - SCAN: ROWS cycles. Row pointer rp runs 0..ROWS-1, one row per cycle.
//      Full row (all COLS bits set): cnt++.
//      Otherwise: out[wp] = work[rp]; wp++.
//    - FILL: 1 cycle. Rows wp..ROWS-1 of out are cleared.
//    - DONE: 1 cycle. Sequence:
//      1. done=1 and hit=(cnt!=0).
//      2. lineCount = (cnt>=4) ? 2'b11 : cnt-1 when cnt!=0, else unchanged.
//      3. board_out = out.
//      4. -> IDLE.
//  - Latency: done is high exactly ROWS+3 cycles after the start cycle (23 at default).
//  - busy is 1 in MERGE, SCAN and FILL; 0 in DONE and IDLE.
//  - start while busy or in DONE is ignored, not queued.
//  - Widths:
//    - rp and wp are 5 bits; wp never exceeds rp+1.
//    - cnt is 5 bits. It can exceed 4 when board_in already holds full rows; lineCount saturates at 11.
//  - Empty piece (float_in=0) with no full rows: board_out=board_in, hit=0.
// CONFIGURATION
//  LC_TOPOUT_EN defined:
//    - MERGE sets gov=1 if any set piece bit overlaps a board_in bit, or lies at y+i>=ROWS or x+j>=COLS.
//    - game_over <= gov at DONE, and stays high until rst.
//  LC_TOPOUT_EN undefined:
//    - Out-of-range cells are silently dropped; overlaps simply OR.
//    - game_over is tied to 0.
// STRUCTURE
//  Package tetris_pkg holds:
//    - ROWS and COLS
//    - BOARD_W = ROWS*COLS
//    - the lc_state_t encoding (IDLE, MERGE, SCAN, FILL, DONE)
//    - the row-full helper function
//  Sub-module lc_float_merge (combinational):
//    - inputs board_in, float_in, x, y
//    - outputs merged board and overlap/out-of-range flag
//  The line_clearer FSM, pointers and row store live in this module.
// TESTING
//  1. rst=1 one cycle, then idle 5 cycles -> busy=done=hit=0, board_out=0, lineCount=00.
//  2. board_in rows 0..3 = cols 0..8 set; float_in = 4 rows with bit j=0 set; x=9, y=0; start
//     -> done at cycle 23; hit=1; lineCount=11; board_out=0.
//  3. Row 0 = 10'h3FE, row 1 = 10'h001; float_in bit0 only; x=0, y=0; start
//     -> hit=1, lineCount=00; board_out row0 = 10'h001, rows 1..19 = 0.
//  4. Empty board; float_in = O piece 0110/0110; x=3, y=18; start
//     -> hit=0, done at cycle 23; board_out rows 18,19 hold bits at cols 4,5.
//  5. Board as in test 2; start, then pulse start again at cycle 5 and assert rst at cycle 10
//     -> no done; state IDLE; all outputs at reset values.
//  6. LC_TOPOUT_EN defined; float bit at (0,0) overlaps board_in bit 0; start
//     -> game_over=1 at done and held. Macro undefined: same stimulus gives game_over=0.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared board geometry, line-clearer state encoding and row helpers.
package tetris_pkg;

  localparam int unsigned ROWS    = 20;
  localparam int unsigned COLS    = 10;
  localparam int unsigned BOARD_W = ROWS * COLS;

  typedef enum logic [2:0] {
    StIdle,
    StMerge,
    StScan,
    StFill,
    StDone
  } lc_state_t;

  function automatic logic row_full(input logic [COLS-1:0] row);
    return &row;
  endfunction

endpackage

// File: rtl/lc_float_merge.sv
// Combinational merge of the 4x4 falling piece into the static board.
// Flags any piece cell that overlaps the board or falls outside it.
module lc_float_merge
  import tetris_pkg::*;
(
  input  logic [BOARD_W-1:0] board_in,
  input  logic [15:0]        float_in,
  input  logic [3:0]         x,
  input  logic [4:0]         y,
  output logic [BOARD_W-1:0] merged,
  output logic               topout
);

  always_comb begin
    merged = board_in;
    topout = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      for (int unsigned j = 0; j < 4; j++) begin
        logic [3:0]  fidx;
        logic [7:0]  bidx;
        int unsigned r;
        int unsigned c;
        fidx = 4'(i * 4 + j);
        r    = int'(y) + i;
        c    = int'(x) + j;
        bidx = '0;
        if (float_in[fidx]) begin
          if (r >= ROWS || c >= COLS) begin
            topout = 1'b1;
          end else begin
            bidx = 8'(r * COLS + c);
            if (board_in[bidx]) topout = 1'b1;
            merged[bidx] = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/line_clearer.sv
// Lock-and-clear stage: merge piece, drop full rows, compact downward.
// Optional lock-out detection is enabled by defining LC_TOPOUT_EN.
module line_clearer
  import tetris_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BOARD_W-1:0] board_in,
  input  logic [15:0]        float_in,
  input  logic [3:0]         x,
  input  logic [4:0]         y,
  output logic               busy,
  output logic               done,
  output logic [BOARD_W-1:0] board_out,
  output logic               hit,
  output logic [1:0]         lineCount,
  output logic               game_over
);

  lc_state_t                     state_q;
  logic [BOARD_W-1:0]            board_q;
  logic [15:0]                   float_q;
  logic [3:0]                    x_q;
  logic [4:0]                    y_q;
  logic [ROWS-1:0][COLS-1:0]     work_q;
  logic [ROWS-1:0][COLS-1:0]     out_q;
  logic [ROWS-1:0][COLS-1:0]     filled;
  logic [4:0]                    rp_q;
  logic [4:0]                    wp_q;
  logic [4:0]                    cnt_q;
  logic [BOARD_W-1:0]            merged;
  logic                          topout;

  lc_float_merge u_merge (
    .board_in (board_q),
    .float_in (float_q),
    .x        (x_q),
    .y        (y_q),
    .merged   (merged),
    .topout   (topout)
  );

  // Rows at or above the write pointer were never written this pass.
  always_comb begin
    filled = out_q;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (5'(r) >= wp_q) filled[5'(r)] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      board_q   <= '0;
      float_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      work_q    <= '0;
      out_q     <= '0;
      rp_q      <= '0;
      wp_q      <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit       <= 1'b0;
      lineCount <= 2'b00;
      board_out <= '0;
    end else begin
      done <= 1'b0;
      hit  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            board_q <= board_in;
            float_q <= float_in;
            x_q     <= x;
            y_q     <= y;
            busy    <= 1'b1;
            state_q <= StMerge;
          end
        end
        StMerge: begin
          work_q  <= merged;
          rp_q    <= '0;
          wp_q    <= '0;
          cnt_q   <= '0;
          state_q <= StScan;
        end
        StScan: begin
          if (row_full(work_q[rp_q])) begin
            cnt_q <= cnt_q + 5'd1;
          end else begin
            out_q[wp_q] <= work_q[rp_q];
            wp_q        <= wp_q + 5'd1;
          end
          if (rp_q == 5'(ROWS - 1)) state_q <= StFill;
          else                      rp_q    <= rp_q + 5'd1;
        end
        StFill: begin
          // Results are registered here so they are valid during the DONE cycle.
          out_q     <= filled;
          board_out <= filled;
          done      <= 1'b1;
          hit       <= (cnt_q != 5'd0);
          if (cnt_q != 5'd0) lineCount <= (cnt_q >= 5'd4) ? 2'b11 : 2'(cnt_q - 5'd1);
          busy      <= 1'b0;
          state_q   <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef LC_TOPOUT_EN
  logic gov_q;
  logic game_over_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      gov_q       <= 1'b0;
      game_over_q <= 1'b0;
    end else if (state_q == StMerge) begin
      gov_q <= topout;
    end else if (state_q == StFill) begin
      game_over_q <= game_over_q | gov_q;
    end
  end

  assign game_over = game_over_q;
`else
  logic unused_topout;
  assign unused_topout = topout;
  assign game_over     = 1'b0;
`endif

endmodule
